muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Execute-stage HI/LO unit of the five-stage MIPS pipeline. It is the receiving end of the decode stage's `oper_o`/`reg1_o`/`reg2_o` issue interface for HI/LO-class operations (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO). It owns the HI/LO registers and runs a 32-iteration radix-2 restoring divider. While a divide is in flight it raises a stall request to the pipeline controller. It returns MFHI/MFLO data on the EX write-back path, which the decode stage forwards from.

## Interface
Parameters:
- `DIV_ITERS`, default 32. Divider iteration count; must equal the Word_t width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active high (`ENABLE`).
- `oper_i`  in  Oper_t  operation currently in EX, from the ID/EX register.
- `reg1_i`  in  Word_t  operand rs, already forwarded; dividend / multiplicand / MTHI-MTLO source.
- `reg2_i`  in  Word_t  operand rt, already forwarded; divisor / multiplier.
- `ex_stall_i`  in  1  controller holds EX this cycle, so `oper_i` is re-presented next cycle.
- `flush_i`  in  1  exception flush; kills any in-flight operation.
- `stallreq_o`  out  1  request to freeze IF/ID/EX.
- `busy_o`  out  1  FSM not in IDLE.
- `wreg_data_o`  out  Word_t  HI for OP_MFHI, LO for OP_MFLO, `ZERO_WORD` otherwise; combinational from current HI/LO.
- `hi_o`, `lo_o`  out  Word_t  architectural HI/LO.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset to IDLE, with HI = LO = 0, iteration counter = 0, `stallreq_o` = 0, `busy_o` = 0.
- IDLE, OP_MULT/OP_MULTU:
  - Writes {HI,LO} = 64-bit signed/unsigned product at the clock edge.
  - No stall.
  - If `ex_stall_i` holds the instruction, it is re-executed with identical operands, which is harmless.
- IDLE, OP_MTHI/OP_MTLO: writes HI/LO from `reg1_i` at the edge. No stall.
- IDLE, OP_DIV/OP_DIVU with `reg2_i` != 0:
  - `stallreq_o` = 1 combinationally.
  - Latch |dividend| and |divisor| (raw values for DIVU), plus the quotient sign (sa^sb) and remainder sign (sa).
  - Go to BUSY with counter = 0.
- IDLE, DIV/DIVU with `reg2_i` == 0:
  - `stallreq_o` = 1.
  - Latch quotient = 0xFFFFFFFF and remainder = dividend.
  - Go directly to DONE.
- BUSY:
  - Each cycle, one restoring step: shift the remainder:quotient pair left by 1, trial-subtract the divisor, set the quotient LSB if the result is non-negative.
  - Counter increments; when it reaches `DIV_ITERS`-1, go to DONE.
  - `stallreq_o` = 1.
- DONE:
  - `stallreq_o` = 0.
  - On the first DONE cycle only, write LO = sign-corrected quotient and HI = sign-corrected remainder.
  - Stay in DONE while `ex_stall_i` = 1; the HI/LO write is not repeated and no restart occurs.
  - Return to IDLE when `ex_stall_i` = 0.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This follows from 32-bit wrap with no special case.
- `flush_i` = 1 in any state: go to IDLE next edge, no HI/LO write, `stallreq_o` deasserted combinationally that cycle. A flush has priority over completion.
- `rst` mid-divide: HI/LO return to 0 and the FSM returns to IDLE.
- Non-HI/LO opcodes in IDLE: no state change.

## Timing
- DIV/DIVU, nonzero divisor, issued in cycle C0:
  - `stallreq_o` is high C0..C32.
  - DONE occurs in C33, when `stallreq_o` = 0.
  - HI/LO are visible from C34.
  - Total: 33 stall cycles.
- Divide by zero: stall in C0 only, DONE in C1, HI/LO visible from C2.
- MULT/MTHI/MTLO: HI/LO visible the cycle after issue. An MFHI/MFLO in the immediately following EX cycle reads the new value; there is no hazard.
- `wreg_data_o` and `stallreq_o` are combinational from state and `oper_i`. There is no register stage on these outputs.

## Configuration
- `MULDIV_ITER_MUL_EN` defined:
  - MULT/MULTU use the same FSM as an iterative shift-add multiplier: 32 BUSY cycles, then DONE.
  - Stall timing matches DIV (33 stall cycles). The signed variant multiplies magnitudes and negates the 64-bit result if sa^sb.
- Not defined: single-cycle combinational 64-bit multiply with no stall, as described above.

## Test plan
- Reset, then MFHI/MFLO: `wreg_data_o` = 0x00000000. Then MTHI 0x12345678; next cycle MFHI returns 0x12345678.
- MULT 0xFFFFFFFE × 0x00000003: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands: HI = 0x00000002, LO = 0xFFFFFFFA. No stall (macro off); 33 stall cycles (macro on).
- DIV −7 / 2 issued at C0: `stallreq_o` high C0..C32; from C34 LO = 0xFFFFFFFD and HI = 0xFFFFFFFF. DIVU 100/7: LO = 14, HI = 2.
- DIV with divisor 0 and dividend 0x55: one stall cycle; then LO = 0xFFFFFFFF, HI = 0x55. DIV 0x80000000 / −1: LO = 0x80000000, HI = 0.
- DIVU completes while `ex_stall_i` is held high for 5 cycles: HI/LO written exactly once, FSM stays in DONE, no second divide starts, then returns to IDLE.
- `flush_i` at C10 of a DIV: IDLE at C11, `stallreq_o` low at C10, HI/LO unchanged from their pre-DIV values.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_unit (with package muldiv_pkg)                       |
// | Description : EX-stage HI/LO unit: MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO|
// |               with a radix-2 restoring divider and pipeline stall request.|
// |               Define MULDIV_ITER_MUL_EN for an iterative shift-add MULT.  |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+

package muldiv_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] Word_t;
  typedef logic [7:0]        Oper_t;

  localparam Word_t ZERO_WORD = '0;

  localparam Oper_t OP_NOP   = 8'h00;
  localparam Oper_t OP_MFHI  = 8'h10;
  localparam Oper_t OP_MTHI  = 8'h11;
  localparam Oper_t OP_MFLO  = 8'h12;
  localparam Oper_t OP_MTLO  = 8'h13;
  localparam Oper_t OP_MULT  = 8'h18;
  localparam Oper_t OP_MULTU = 8'h19;
  localparam Oper_t OP_DIV   = 8'h1a;
  localparam Oper_t OP_DIVU  = 8'h1b;
endpackage

module muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  oper_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        ex_stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic [31:0] wreg_data_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  import muldiv_pkg::*;

  localparam int              CNT_W      = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV_ITERS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_rem;
  logic [31:0]      r_quo;
  logic [31:0]      r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_pend;
  logic [CNT_W-1:0] r_cnt;

  logic        w_is_div;
  logic        w_is_mul;
  logic        w_signed;
  logic        w_iter_start;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [32:0] w_trial;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_is_div = (oper_i == OP_DIV) || (oper_i == OP_DIVU);
  assign w_is_mul = (oper_i == OP_MULT) || (oper_i == OP_MULTU);
  assign w_signed = (oper_i == OP_DIV) || (oper_i == OP_MULT);
  assign w_a_neg  = w_signed & reg1_i[31];
  assign w_b_neg  = w_signed & reg2_i[31];
  assign w_a_abs  = w_a_neg ? -reg1_i : reg1_i;
  assign w_b_abs  = w_b_neg ? -reg2_i : reg2_i;

  // Trial subtraction on the left-shifted remainder; bit 32 set means "borrow".
  assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_dsr};
  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

`ifdef MULDIV_ITER_MUL_EN
  logic        r_is_mul;
  logic [32:0] w_acc;
  logic [63:0] w_prod_fix;

  assign w_iter_start = w_is_div | w_is_mul;
  assign w_acc        = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dsr} : 33'd0);
  assign w_prod_fix   = r_neg_q ? -{r_rem, r_quo} : {r_rem, r_quo};
`else
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;

  assign w_iter_start = w_is_div;
  // Low 64 bits of a sign-extended product equal the signed 64-bit product.
  assign w_mul_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
  assign w_mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};
`endif

  assign stallreq_o = !flush_i &&
                      (((r_state == S_IDLE) && w_iter_start) || (r_state == S_BUSY));
  assign busy_o = (r_state != S_IDLE);
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

  always_comb begin
    wreg_data_o = ZERO_WORD;
    if (oper_i == OP_MFHI)      wreg_data_o = r_hi;
    else if (oper_i == OP_MFLO) wreg_data_o = r_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
`ifdef MULDIV_ITER_MUL_EN
      r_is_mul <= 1'b0;
`endif
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
`ifdef MULDIV_ITER_MUL_EN
            r_is_mul <= 1'b0;
`endif
            if (reg2_i == '0) begin
              r_quo   <= 32'hFFFF_FFFF;
              r_rem   <= reg1_i;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_pend  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_dsr   <= w_b_abs;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= '0;
              r_state <= S_BUSY;
            end
          end else if (w_is_mul) begin
`ifdef MULDIV_ITER_MUL_EN
            r_is_mul <= 1'b1;
            r_rem    <= '0;
            r_quo    <= w_b_abs;
            r_dsr    <= w_a_abs;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_BUSY;
`else
            {r_hi, r_lo} <= (oper_i == OP_MULT) ? w_mul_s : w_mul_u;
`endif
          end else if (oper_i == OP_MTHI) begin
            r_hi <= reg1_i;
          end else if (oper_i == OP_MTLO) begin
            r_lo <= reg1_i;
          end
        end

        S_BUSY: begin
`ifdef MULDIV_ITER_MUL_EN
          if (r_is_mul) begin
            r_rem <= w_acc[32:1];
            r_quo <= {w_acc[0], r_quo[31:1]};
          end else
`endif
          if (!w_trial[32]) begin
            r_rem <= w_trial[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= {r_rem[30:0], r_quo[31]};
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_cnt <= r_cnt + C_CNT_ONE;
          if (r_cnt == C_CNT_LAST) begin
            r_pend  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // Results commit once; a held DONE must not rewrite or restart.
          if (r_pend) begin
`ifdef MULDIV_ITER_MUL_EN
            if (r_is_mul) begin
              {r_hi, r_lo} <= w_prod_fix;
            end else begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
            end
`else
            r_lo <= w_q_fix;
            r_hi <= w_r_fix;
`endif
            r_pend <= 1'b0;
          end
          if (!ex_stall_i) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// Self-checking bench for muldiv_unit: directed test-plan cases plus
// randomized operations checked every cycle against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_ITER_MUL_EN
  localparam bit ITER_MUL = 1'b1;
`else
  localparam bit ITER_MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  oper;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        ex_stall;
  logic        flush;
  logic        stallreq_o;
  logic        busy_o;
  logic [31:0] wreg_data_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  always #5 clk = ~clk;

  muldiv_unit #(.DIV_ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .oper_i     (oper),
    .reg1_i     (r1),
    .reg2_i     (r2),
    .ex_stall_i (ex_stall),
    .flush_i    (flush),
    .stallreq_o (stallreq_o),
    .busy_o     (busy_o),
    .wreg_data_o(wreg_data_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_seen = 0;
  bit          chk_en = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        e_stall = 1'b0;
  logic        e_busy  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare of every output against the model state.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (stallreq_o === 1'b1) stall_seen++;
    if (chk_en) begin
      exp_w = (oper == OP_MFHI) ? m_hi : (oper == OP_MFLO) ? m_lo : 32'd0;
      chk("stallreq", {31'd0, stallreq_o}, {31'd0, e_stall});
      chk("busy", {31'd0, busy_o}, {31'd0, e_busy});
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      chk("wreg_data", wreg_data_o, exp_w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result {hi,lo} of one operation, from plain arithmetic.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint la, lb, ma, mb, q, r, p;
    logic [63:0] res;
    res = {hi, lo};
    la = $signed(a);
    lb = $signed(b);
    case (op)
      OP_MULT:  begin p = la * lb; res = p; end
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          ma = (la < 0) ? -la : la;
          mb = (lb < 0) ? -lb : lb;
          q = ma / mb;
          r = ma % mb;
          if ((la < 0) != (lb < 0)) q = -q;
          if (la < 0) r = -r;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_MTHI: res = {a, lo};
      OP_MTLO: res = {hi, a};
      default: res = {hi, lo};
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [63:0] nxt;
    bit is_div, multi, zero;
    nxt    = model(op, a, b, m_hi, m_lo);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    multi  = is_div || (ITER_MUL && ((op == OP_MULT) || (op == OP_MULTU)));
    zero   = is_div && (b == 0);
    oper = op; r1 = a; r2 = b;
    e_busy = 1'b0; e_stall = multi; ex_stall = multi;
    if (!multi) begin
      tick();
      {m_hi, m_lo} = nxt;
      for (int k = 0; k < hold; k++) begin
        ex_stall = 1'b1;
        tick();
      end
    end else begin
      tick();
      if (!zero) begin
        for (int k = 0; k < 32; k++) begin
          e_busy = 1'b1; e_stall = 1'b1;
          tick();
        end
      end
      for (int k = 0; k <= hold; k++) begin
        e_busy = 1'b1; e_stall = 1'b0; ex_stall = (k < hold);
        tick();
        if (k == 0) {m_hi, m_lo} = nxt;
      end
    end
    oper = OP_NOP; ex_stall = 1'b0; e_busy = 1'b0; e_stall = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int s0;
    logic [7:0] ops [11];
    logic [7:0] op;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO,
            OP_MTHI, OP_MTLO, OP_NOP, 8'h21, 8'hFF};

    rst = 1'b1; oper = OP_NOP; r1 = '0; r2 = '0; ex_stall = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;

    // Reset values through the read path.
    oper = OP_MFHI; #1;
    chk("reset_mfhi", wreg_data_o, 32'h0000_0000);
    oper = OP_MFLO; #1;
    chk("reset_mflo", wreg_data_o, 32'h0000_0000);
    tick();

    do_op(OP_MTHI, 32'h1234_5678, 32'd0, 0);
    oper = OP_MFHI; #1;
    chk("mthi_then_mfhi", wreg_data_o, 32'h1234_5678);
    tick();

    s0 = stall_seen;
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);
    chk("mult_stalls", 32'(stall_seen - s0), ITER_MUL ? 32'd33 : 32'd0);
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    chk("multu_hi", hi_o, 32'h0000_0002);
    chk("multu_lo", lo_o, 32'hFFFF_FFFA);

    s0 = stall_seen;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_stalls", 32'(stall_seen - s0), 32'd33);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);

    do_op(OP_DIVU, 32'd100, 32'd7, 0);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);

    s0 = stall_seen;
    do_op(OP_DIV, 32'h55, 32'd0, 0);
    chk("div0_stalls", 32'(stall_seen - s0), 32'd1);
    chk("div0_lo", lo_o, 32'hFFFF_FFFF);
    chk("div0_hi", hi_o, 32'h0000_0055);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("divmin_lo", lo_o, 32'h8000_0000);
    chk("divmin_hi", hi_o, 32'h0000_0000);

    // Completion held in DONE for 5 extra cycles.
    s0 = stall_seen;
    do_op(OP_DIVU, 32'd1000, 32'd3, 5);
    chk("hold_stalls", 32'(stall_seen - s0), 32'd33);
    chk("hold_lo", lo_o, 32'd333);
    chk("hold_hi", hi_o, 32'd1);

    // Flush at C10 of a DIV.
    do_op(OP_MTHI, 32'hCAFE_0001, 32'd0, 0);
    do_op(OP_MTLO, 32'hBEEF_0002, 32'd0, 0);
    oper = OP_DIV; r1 = 32'd12345; r2 = 32'd7;
    e_stall = 1'b1; e_busy = 1'b0; ex_stall = 1'b1;
    tick();
    for (int k = 1; k < 10; k++) begin
      e_busy = 1'b1; e_stall = 1'b1;
      tick();
    end
    flush = 1'b1; e_stall = 1'b0; e_busy = 1'b1;
    tick();
    flush = 1'b0; oper = OP_NOP; ex_stall = 1'b0; e_busy = 1'b0; e_stall = 1'b0;
    #1;
    chk("flush_idle", {31'd0, busy_o}, 32'd0);
    chk("flush_hi", hi_o, 32'hCAFE_0001);
    chk("flush_lo", lo_o, 32'hBEEF_0002);
    tick();

    // Reset in the middle of a divide.
    oper = OP_DIV; r1 = 32'd999; r2 = 32'd5;
    e_stall = 1'b1; ex_stall = 1'b1;
    tick();
    e_busy = 1'b1;
    tick(); tick();
    chk_en = 1'b0; rst = 1'b1; oper = OP_NOP; ex_stall = 1'b0;
    tick();
    rst = 1'b0; m_hi = '0; m_lo = '0; e_busy = 1'b0; e_stall = 1'b0; chk_en = 1'b1;
    #1;
    chk("rst_mid_hi", hi_o, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    tick();

    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 10)];
      if (op == OP_DIV || op == OP_DIVU) do_op(op, rnd_word(), rnd_word(), $urandom_range(0, 3));
      else                               do_op(op, rnd_word(), rnd_word(), $urandom_range(0, 1));
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
